// File: rtl/alu_param_hs_if.sv
// alu_param_hs_if: operand request / result handshake bundle for alu_param_hs
interface alu_param_hs_if #(
    parameter int WIDTH     = 8,
    parameter int CTR_WIDTH = 10
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2:0]           op;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic                 carry;
    logic                 zero;
    logic                 negative;
    logic                 overflow;
    logic [CTR_WIDTH-1:0] op_count;
    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, result, carry, zero, negative, overflow, op_count
    );
    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, result, carry, zero, negative, overflow, op_count
    );
endinterface

// File: rtl/alu_param_hs.sv
// alu_param_hs: handshaked multi-cycle ALU (IDLE/EXEC/WB/DONE), WIDTH-bit datapath,
// add/sub/logic/shift ops with carry, zero, negative, overflow and a wrapping op counter.
module alu_param_hs #(
    parameter int WIDTH     = 8,
    parameter int CTR_WIDTH = 10
) (
    input logic           clk,
    input logic           rst_n,
    alu_param_hs_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, EXEC, WB, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_c;
    logic [2:0]       op_q;
    logic             c_q, v_q, c_c, v_c;
    logic [SHW-1:0]   s;
    logic [WIDTH:0]   sum, diff, shl, shr;
    assign s    = b_q[SHW-1:0];
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};
    // Extra bit on each shift catches the last bit shifted out (0 when s == 0)
    assign shl  = {1'b0, a_q} << s;
    assign shr  = {a_q, 1'b0} >> s;
    assign bus.in_ready = (state == IDLE);
    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        case (op_q)
            3'b000: begin
                res_c = sum[WIDTH-1:0];
                c_c   = sum[WIDTH];
                v_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b001: begin
                res_c = diff[WIDTH-1:0];
                c_c   = diff[WIDTH];
                v_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b010: res_c = a_q & b_q;
            3'b011: res_c = a_q | b_q;
            3'b100: res_c = a_q ^ b_q;
            3'b101: begin
                res_c = shl[WIDTH-1:0];
                c_c   = shl[WIDTH];
            end
            3'b110: begin
                res_c = shr[WIDTH:1];
                c_c   = shr[0];
            end
            default: begin
                res_c = $signed(a_q) >>> s;
                c_c   = shr[0];
            end
        endcase
    end
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = bus.in_valid ? EXEC : IDLE;
            EXEC:    state_nx = WB;
            WB:      state_nx = DONE;
            DONE:    state_nx = (bus.out_valid && bus.out_ready) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            res_q        <= '0;
            c_q          <= 1'b0;
            v_q          <= 1'b0;
            bus.result   <= '0;
            bus.carry    <= 1'b0;
            bus.zero     <= 1'b0;
            bus.negative <= 1'b0;
            bus.overflow <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.op_count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.in_valid) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= bus.op;
            end
            if (state == EXEC) begin
                res_q <= res_c;
                c_q   <= c_c;
                v_q   <= v_c;
            end
            if (state == WB) begin
                bus.result    <= res_q;
                bus.carry     <= c_q;
                bus.zero      <= (res_q == '0);
                bus.negative  <= res_q[WIDTH-1];
                bus.overflow  <= v_q;
                bus.out_valid <= 1'b1;
            end
            if (state == DONE && bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.op_count  <= bus.op_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_param_hs.sv
// tb_alu_param_hs: directed vector table plus backpressure, mid-op reset and counter wrap checks
module tb_alu_param_hs;
    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b, res;
        logic       c, z, n, v;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [3:0] exp_cnt = '0;
    vec_t vt[16];
    alu_param_hs_if #(.WIDTH(8), .CTR_WIDTH(4)) bus();
    alu_param_hs #(.WIDTH(8), .CTR_WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.op = op;
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        chk("in_ready before accept", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask
    task automatic run_vec(input vec_t v, input int idx);
        bus.out_ready = 1'b1;
        issue(v.op, v.a, v.b);
        @(negedge clk) chk($sformatf("v%0d out_valid N+0", idx), 32'(bus.out_valid), 0);
        @(negedge clk) chk($sformatf("v%0d out_valid N+1", idx), 32'(bus.out_valid), 0);
        @(negedge clk);
        chk($sformatf("v%0d out_valid N+2", idx), 32'(bus.out_valid), 1);
        chk($sformatf("v%0d result", idx), 32'(bus.result), 32'(v.res));
        chk($sformatf("v%0d flags czn v", idx),
            32'({bus.carry, bus.zero, bus.negative, bus.overflow}), 32'({v.c, v.z, v.n, v.v}));
        @(posedge clk);
        #1 exp_cnt++;
        chk($sformatf("v%0d out_valid after hs", idx), 32'(bus.out_valid), 0);
        chk($sformatf("v%0d in_ready after hs", idx), 32'(bus.in_ready), 1);
        chk($sformatf("v%0d op_count", idx), 32'(bus.op_count), 32'(exp_cnt));
    endtask
    initial begin
        //        op      A      B      res    c     z     n     v
        vt[0]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[2]  = '{3'b001, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{3'b101, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{3'b111, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{3'b110, 8'h05, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{3'b100, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[10] = '{3'b110, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[11] = '{3'b111, 8'h81, 8'h01, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[12] = '{3'b101, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[13] = '{3'b001, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[14] = '{3'b000, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[15] = '{3'b101, 8'h01, 8'h09, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.op = '0;
        #12;
        chk("reset result", 32'(bus.result), 0);
        chk("reset flags", 32'({bus.carry, bus.zero, bus.negative, bus.overflow}), 0);
        chk("reset out_valid", 32'(bus.out_valid), 0);
        chk("reset op_count", 32'(bus.op_count), 0);
        chk("reset in_ready", 32'(bus.in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk) chk("idle out_valid", 32'(bus.out_valid), 0);
        for (int i = 0; i < 16; i++) run_vec(vt[i], i);
        chk("op_count wrap", 32'(bus.op_count), 0);
        // Backpressure: result held, inputs ignored while DONE waits on out_ready
        bus.out_ready = 1'b0;
        issue(3'b000, 8'h01, 8'h02);
        repeat (3) @(negedge clk);
        chk("bp out_valid", 32'(bus.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            bus.A = 8'(i * 37 + 5);
            bus.B = 8'(i * 11 + 1);
            bus.op = 3'(i + 1);
            bus.in_valid = ~bus.in_valid;
            @(negedge clk);
            chk("bp result", 32'(bus.result), 32'h03);
            chk("bp flags", 32'({bus.carry, bus.zero, bus.negative, bus.overflow}), 0);
            chk("bp out_valid hold", 32'(bus.out_valid), 1);
            chk("bp in_ready", 32'(bus.in_ready), 0);
            chk("bp op_count", 32'(bus.op_count), 32'(exp_cnt));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 exp_cnt++;
        chk("bp hs out_valid", 32'(bus.out_valid), 0);
        chk("bp hs op_count", 32'(bus.op_count), 32'(exp_cnt));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post hs out_valid", 32'(bus.out_valid), 0);
            chk("post hs op_count", 32'(bus.op_count), 32'(exp_cnt));
            chk("post hs result kept", 32'(bus.result), 32'h03);
        end
        // Reset while the op is in EXEC discards it
        issue(3'b001, 8'h05, 8'h03);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midreset result", 32'(bus.result), 0);
        chk("midreset op_count", 32'(bus.op_count), 0);
        chk("midreset out_valid", 32'(bus.out_valid), 0);
        chk("midreset in_ready", 32'(bus.in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        exp_cnt = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("after midreset out_valid", 32'(bus.out_valid), 0);
            chk("after midreset in_ready", 32'(bus.in_ready), 1);
        end
        run_vec(vt[1], 99);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
